pcileech_ft601_responder: RTL and testbench

- Synthesizable model of the FT601 chip side of the 245 synchronous FIFO bus.
- It is the responder that the FPGA-side FT601 controller talks to.
- Used in simulation and in board loopback self-test. It replaces the USB3 chip.
- A host-side push/pop interface feeds words toward the FPGA and drains words written by the FPGA, with flow-control and error injection.

---
 rtl/pcileech_ft601_responder.sv | 158 +++++++++++++++
 tb/tb_pcileech_ft601_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_ft601_responder.sv
// FT601-side responder for the 245 synchronous FIFO bus: host push/pop FIFOs on one side,
// FT601 strobes and status flags on the other, with stall injection and saturating error counters.
module pcileech_ft601_responder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ft601_data_i,
  output logic [31:0]          ft601_data_o,
  output logic                 ft601_data_oe,
  input  logic [3:0]           ft601_be,
  output logic                 ft601_rxf_n,
  output logic                 ft601_txe_n,
  input  logic                 ft601_wr_n,
  input  logic                 ft601_rd_n,
  input  logic                 ft601_oe_n,
  input  logic                 ft601_siwu_n,
  input  logic [31:0]          host_tx_data,
  input  logic                 host_tx_valid,
  output logic                 host_tx_full,
  output logic [35:0]          host_rx_data,
  output logic                 host_rx_valid,
  input  logic                 host_rx_ready,
  input  logic                 inj_rxf_stall,
  input  logic                 inj_txe_stall,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  output logic [CNT_WIDTH-1:0] udf_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic [1:0]            rst_sync_q;
  logic                  rst_sync_n;
  state_t                state_q;
  logic                  data_oe_q, rxf_n_q, txe_n_q, tx_full_q, rx_valid_q;
  logic [31:0]           tx_mem [DEPTH];
  logic [35:0]           rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0]         tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
  logic [CNT_WIDTH-1:0]  ovf_q, udf_q, err_q;
  logic                  tx_push, tx_drop, tx_pop, rd_udf;
  logic                  wr_req, wr_err, rx_push, wr_ovf, rx_pop;
  logic [1:0]            ovf_inc;
  logic                  unused_siwu;

  assign unused_siwu = ft601_siwu_n;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  assign tx_push = host_tx_valid && !tx_full_q;
  assign tx_drop = host_tx_valid && tx_full_q;
  assign tx_pop  = (state_q == S_RD) && !ft601_rd_n && !rxf_n_q && data_oe_q;
  assign rd_udf  = !ft601_rd_n && rxf_n_q;

  // A write colliding with an active or turning-around read bus is a protocol error, never stored.
  assign wr_req  = !ft601_wr_n;
  assign wr_err  = wr_req && (!ft601_oe_n || data_oe_q);
  assign rx_push = wr_req && !wr_err && !txe_n_q;
  assign wr_ovf  = wr_req && !wr_err && txe_n_q;
  assign rx_pop  = rx_valid_q && host_rx_ready;
  assign ovf_inc = {1'b0, tx_drop} + {1'b0, wr_ovf};

  assign tx_cnt_d = tx_cnt_q + {{(CW-1){1'b0}}, tx_push} - {{(CW-1){1'b0}}, tx_pop};
  assign rx_cnt_d = rx_cnt_q + {{(CW-1){1'b0}}, rx_push} - {{(CW-1){1'b0}}, rx_pop};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= host_tx_data;
    if (rx_push) rx_mem[rx_wr_q] <= {ft601_be, ft601_data_i};
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q    <= S_IDLE;
      data_oe_q  <= 1'b0;
      rxf_n_q    <= 1'b1;
      txe_n_q    <= 1'b0;
      tx_full_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      ovf_q      <= '0;
      udf_q      <= '0;
      err_q      <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PTR_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_ONE;
      if (rx_push) rx_wr_q <= rx_wr_q + PTR_ONE;
      if (rx_pop)  rx_rd_q <= rx_rd_q + PTR_ONE;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_full_q  <= (tx_cnt_d == FULL_CNT);
      rx_valid_q <= (rx_cnt_d != '0);
      rxf_n_q    <= (tx_cnt_d == '0) || inj_rxf_stall;
      txe_n_q    <= (rx_cnt_d == FULL_CNT) || inj_txe_stall;
      ovf_q      <= sat_add(ovf_q, ovf_inc);
      udf_q      <= sat_add(udf_q, {1'b0, rd_udf});
      err_q      <= sat_add(err_q, {1'b0, wr_err});
      case (state_q)
        S_IDLE: begin
          if (!ft601_oe_n && ft601_wr_n && !rxf_n_q) begin
            state_q   <= S_RD;
            data_oe_q <= 1'b1;
          end else if (wr_req && ft601_oe_n) begin
            state_q <= S_WR;
          end
        end
        S_RD: begin
          if (ft601_oe_n) begin
            state_q   <= S_IDLE;
            data_oe_q <= 1'b0;
          end
        end
        S_WR: begin
          if (ft601_wr_n) state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign ft601_data_o  = data_oe_q ? tx_mem[tx_rd_q] : '0;
  assign ft601_data_oe = data_oe_q;
  assign ft601_rxf_n   = rxf_n_q;
  assign ft601_txe_n   = txe_n_q;
  assign host_tx_full  = tx_full_q;
  assign host_rx_data  = rx_mem[rx_rd_q];
  assign host_rx_valid = rx_valid_q;
  assign ovf_cnt       = ovf_q;
  assign udf_cnt       = udf_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// Directed bench for pcileech_ft601_responder with queue-based expected data.
module tb_pcileech_ft601_responder;
  localparam int DL = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   ft601_data_i, ft601_data_o;
  logic          ft601_data_oe;
  logic [3:0]    ft601_be;
  logic          ft601_rxf_n, ft601_txe_n;
  logic          ft601_wr_n, ft601_rd_n, ft601_oe_n, ft601_siwu_n;
  logic [31:0]   host_tx_data;
  logic          host_tx_valid, host_tx_full;
  logic [35:0]   host_rx_data;
  logic          host_rx_valid, host_rx_ready;
  logic          inj_rxf_stall, inj_txe_stall;
  logic [CW-1:0] ovf_cnt, udf_cnt, err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] txq[$];
  logic [35:0] rxq[$];

  always #5 clk = ~clk;

  pcileech_ft601_responder #(.DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ft601_data_i(ft601_data_i), .ft601_data_o(ft601_data_o), .ft601_data_oe(ft601_data_oe),
    .ft601_be(ft601_be), .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
    .ft601_wr_n(ft601_wr_n), .ft601_rd_n(ft601_rd_n), .ft601_oe_n(ft601_oe_n),
    .ft601_siwu_n(ft601_siwu_n),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_full(host_tx_full),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .inj_rxf_stall(inj_rxf_stall), .inj_txe_stall(inj_txe_stall),
    .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ft601_wr_n = 1'b1; ft601_rd_n = 1'b1; ft601_oe_n = 1'b1; ft601_siwu_n = 1'b1;
    ft601_data_i = '0; ft601_be = '0;
    host_tx_valid = 1'b0; host_tx_data = '0; host_rx_ready = 1'b0;
    inj_rxf_stall = 1'b0; inj_txe_stall = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    txq.delete();
    rxq.delete();
  endtask

  task automatic push_tx(input logic [31:0] d);
    host_tx_valid = 1'b1;
    host_tx_data  = d;
    txq.push_back(d);
    step();
    host_tx_valid = 1'b0;
  endtask

  task automatic drain_rx();
    host_rx_ready = 1'b1;
    for (int k = 0; k < 40 && rxq.size() > 0; k++) begin
      if (host_rx_valid) chk("rx_drain_data", host_rx_data, rxq.pop_front());
      step();
    end
    host_rx_ready = 1'b0;
    chk("rx_drain_left", rxq.size(), 0);
    chk("rx_drain_valid", host_rx_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tcnt, rcnt;
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Reset with words in flight
    push_tx(32'hA1); push_tx(32'hA2); push_tx(32'hA3);
    chk("pre_reset_rxf_n", ft601_rxf_n, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_rxf_n", ft601_rxf_n, 1'b1);
    chk("rst_txe_n", ft601_txe_n, 1'b0);
    chk("rst_data_oe", ft601_data_oe, 1'b0);
    chk("rst_data_o", ft601_data_o, 32'h0);
    chk("rst_rx_valid", host_rx_valid, 1'b0);
    chk("rst_tx_full", host_tx_full, 1'b0);
    chk("rst_ovf", ovf_cnt, 16'h0);
    chk("rst_udf", udf_cnt, 16'h0);
    chk("rst_err", err_cnt, 16'h0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_rxf_n", ft601_rxf_n, 1'b1);
    txq.delete();

    // Read burst
    push_tx(32'h11111111); push_tx(32'h22222222); push_tx(32'h33333333); push_tx(32'h44444444);
    ft601_oe_n = 1'b0;
    step();
    chk("rd_data_oe", ft601_data_oe, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ft601_rd_n = 1'b0;
      chk("rd_data_o", ft601_data_o, txq.pop_front());
      step();
    end
    ft601_rd_n = 1'b1;
    chk("rd_rxf_n_empty", ft601_rxf_n, 1'b1);
    chk("rd_udf", udf_cnt, 16'h0);
    ft601_oe_n = 1'b1;
    step();
    chk("rd_oe_off", ft601_data_oe, 1'b0);

    // Write to full
    do_reset();
    rcnt = 0;
    for (int i = 0; i < 18; i++) begin
      ft601_wr_n = 1'b0;
      ft601_data_i = i;
      ft601_be = 4'hF;
      chk("wf_txe_n", ft601_txe_n, rcnt == 16);
      if (rcnt < 16) begin
        rxq.push_back({4'hF, 32'(i)});
        rcnt++;
      end
      step();
    end
    ft601_wr_n = 1'b1;
    chk("wf_ovf", ovf_cnt, 16'd2);
    chk("wf_txe_n_full", ft601_txe_n, 1'b1);
    step();
    drain_rx();
    step();
    chk("wf_txe_n_after", ft601_txe_n, 1'b0);

    // Wrap-around, TX direction
    do_reset();
    tcnt = 0;
    push_tx(32'h00001000);
    tcnt = 1;
    ft601_oe_n = 1'b0;
    step();
    for (int i = 1; i <= 40; i++) begin
      host_tx_valid = 1'b1;
      host_tx_data  = 32'hA0000000 + i;
      chk("wt_rxf_n", ft601_rxf_n, tcnt == 0);
      chk("wt_full", host_tx_full, tcnt == 16);
      ft601_rd_n = (tcnt == 0);
      if (tcnt > 0) chk("wt_data_o", ft601_data_o, txq.pop_front());
      txq.push_back(host_tx_data);
      step();
      tcnt = tcnt + 1 - ((ft601_rd_n == 1'b0) ? 1 : 0);
    end
    host_tx_valid = 1'b0;
    for (int k = 0; k < 20 && tcnt > 0; k++) begin
      ft601_rd_n = 1'b0;
      chk("wt_drain_o", ft601_data_o, txq.pop_front());
      step();
      tcnt--;
    end
    ft601_rd_n = 1'b1;
    chk("wt_rxf_n_end", ft601_rxf_n, 1'b1);
    chk("wt_udf", udf_cnt, 16'h0);
    ft601_oe_n = 1'b1;
    step();
    step();

    // Wrap-around, RX direction
    rcnt = 0;
    host_rx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic pop;
      ft601_wr_n = 1'b0;
      ft601_data_i = i * 3 + 7;
      ft601_be = 4'(i);
      chk("wr_valid", host_rx_valid, rcnt != 0);
      chk("wr_txe_n", ft601_txe_n, rcnt == 16);
      pop = (rcnt != 0);
      if (pop) chk("wr_rx_data", host_rx_data, rxq.pop_front());
      rxq.push_back({4'(i), 32'(i * 3 + 7)});
      step();
      rcnt = rcnt + 1 - (pop ? 1 : 0);
    end
    ft601_wr_n = 1'b1;
    host_rx_ready = 1'b0;
    drain_rx();
    chk("wr_err", err_cnt, 16'h0);
    chk("wr_ovf", ovf_cnt, 16'h0);

    // Protocol violation
    do_reset();
    ft601_wr_n = 1'b0;
    ft601_oe_n = 1'b0;
    ft601_data_i = 32'hDEADBEEF;
    ft601_be = 4'hF;
    step();
    step();
    ft601_wr_n = 1'b1;
    ft601_oe_n = 1'b1;
    step();
    chk("pv_err", err_cnt, 16'd2);
    chk("pv_rx_valid", host_rx_valid, 1'b0);
    chk("pv_ovf", ovf_cnt, 16'h0);
    chk("pv_oe", ft601_data_oe, 1'b0);

    // Stall injection
    do_reset();
    push_tx(32'h5A5A0001);
    push_tx(32'h5A5A0002);
    chk("st_rxf_n_ready", ft601_rxf_n, 1'b0);
    inj_rxf_stall = 1'b1;
    step();
    chk("st_rxf_n_stall", ft601_rxf_n, 1'b1);
    ft601_rd_n = 1'b0;
    repeat (3) step();
    ft601_rd_n = 1'b1;
    chk("st_udf", udf_cnt, 16'd3);
    inj_rxf_stall = 1'b0;
    step();
    chk("st_rxf_n_release", ft601_rxf_n, 1'b0);
    ft601_oe_n = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      ft601_rd_n = 1'b0;
      chk("st_data_o", ft601_data_o, txq.pop_front());
      step();
    end
    ft601_rd_n = 1'b1;
    chk("st_rxf_n_empty", ft601_rxf_n, 1'b1);
    ft601_oe_n = 1'b1;
    step();
    step();
    inj_txe_stall = 1'b1;
    step();
    chk("st_txe_n_stall", ft601_txe_n, 1'b1);
    ft601_wr_n = 1'b0;
    ft601_data_i = 32'h12345678;
    step();
    ft601_wr_n = 1'b1;
    inj_txe_stall = 1'b0;
    step();
    chk("st_txe_ovf", ovf_cnt, 16'd1);
    chk("st_txe_rx_valid", host_rx_valid, 1'b0);
    chk("st_txe_n_release", ft601_txe_n, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
